// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - pipeline/memory bus bundle for the memory-stage controller
//
// Groups the pipeline request, memory strobe and response signals.
//   slave  : the controller (takes requests and memory responses, drives strobes/results)
//   master : the environment (pipeline and memory side)
//   req_valid/req_op/req_indirect/req_addr/req_wdata : pipeline access request
//   mem_resp/mem_rdata                               : memory completion and read data
//   mem_read/mem_write/mem_wmask/mem_address/mem_wdata : memory strobes and bus
//   rsp_valid/rsp_rdata/stall/err                    : pipeline result, hold and timeout pulse

interface mem_stage_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                      req_valid;
    logic [1:0]                req_op;
    logic                      req_indirect;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic                      mem_resp;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      mem_read;
    logic                      mem_write;
    logic [DATA_WIDTH/8-1:0]   mem_wmask;
    logic [ADDR_WIDTH-1:0]     mem_address;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic                      rsp_valid;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      stall;
    logic                      err;

    modport slave (
        input  req_valid, req_op, req_indirect, req_addr, req_wdata, mem_resp, mem_rdata,
        output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        output rsp_valid, rsp_rdata, stall, err
    );

    modport master (
        output req_valid, req_op, req_indirect, req_addr, req_wdata, mem_resp, mem_rdata,
        input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
        input  rsp_valid, rsp_rdata, stall, err
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage access controller (load/store word/byte, optional indirect)
//
// Accepts one pipeline memory access at a time, drives the memory strobes until
// mem_resp (or a wait-cycle timeout) and returns a one-cycle rsp_valid pulse.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_stage_ctrl_if.slave (request, memory bus, response, stall, err)
// Build option:
//   MEM_STAGE_INDIRECT_EN defined -> PTR state and pointer register present,
//   req_indirect honoured (LDI/STI). Undefined -> every access is IDLE->ACCESS.
// The interface instance must use the same DATA_WIDTH/ADDR_WIDTH as this module.

module mem_stage_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int WAIT_LIMIT = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_stage_ctrl_if.slave    bus
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_LIMIT);
    localparam logic [NB-1:0]    LANE0_OH = {{(NB-1){1'b0}}, 1'b1};

`ifdef MEM_STAGE_INDIRECT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_PTR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1} state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [1:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [LANE_W-1:0]     lane;
    logic [7:0]            rd_byte;
    logic                  is_store;
    logic                  is_byte;
    logic                  timeout;

`ifdef MEM_STAGE_INDIRECT_EN
    logic                  ind_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    assign eff_addr = ind_q ? ptr_q : addr_q;
`else
    logic unused_indirect;
    assign unused_indirect = bus.req_indirect;
    assign eff_addr = addr_q;
`endif

    assign is_store = op_q[1];
    assign is_byte  = op_q[0];
    assign lane     = eff_addr[LANE_W-1:0];
    assign rd_byte  = bus.mem_rdata[{lane, 3'b000} +: 8];
    // A response in the limit cycle takes priority, so mem_resp masks the timeout.
    assign timeout  = (WAIT_LIMIT != 0) && (state_q != S_IDLE) && !bus.mem_resp
                      && (cnt_q == LIMIT);

    always_comb begin
        state_d         = state_q;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_wmask   = '0;
        bus.mem_address = '0;
        bus.mem_wdata   = '0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_rdata   = '0;
        bus.stall       = 1'b0;
        bus.err         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    bus.stall = 1'b1;
`ifdef MEM_STAGE_INDIRECT_EN
                    state_d = bus.req_indirect ? S_PTR : S_ACCESS;
`else
                    state_d = S_ACCESS;
`endif
                end
            end
`ifdef MEM_STAGE_INDIRECT_EN
            S_PTR: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = addr_q;
                bus.stall       = 1'b1;
                if (bus.mem_resp) begin
                    state_d = S_ACCESS;
                end else if (timeout) begin
                    bus.err       = 1'b1;
                    bus.rsp_valid = 1'b1;
                    bus.stall     = 1'b0;
                    state_d       = S_IDLE;
                end
            end
`endif
            S_ACCESS: begin
                bus.mem_address = eff_addr;
                bus.stall       = 1'b1;
                if (is_store) begin
                    bus.mem_write = 1'b1;
                    if (is_byte) begin
                        bus.mem_wmask = LANE0_OH << lane;
                        bus.mem_wdata = DATA_WIDTH'(wdata_q[7:0]) << {lane, 3'b000};
                    end else begin
                        bus.mem_wmask = '1;
                        bus.mem_wdata = wdata_q;
                    end
                end else begin
                    bus.mem_read = 1'b1;
                end
                if (bus.mem_resp) begin
                    bus.rsp_valid = 1'b1;
                    bus.stall     = 1'b0;
                    state_d       = S_IDLE;
                    if (!is_store) begin
                        bus.rsp_rdata = is_byte ? DATA_WIDTH'(rd_byte) : bus.mem_rdata;
                    end
                end else if (timeout) begin
                    bus.err       = 1'b1;
                    bus.rsp_valid = 1'b1;
                    bus.stall     = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // State is already IDLE under reset; only the req_valid term of stall needs masking.
        if (rst) begin
            bus.stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MEM_STAGE_INDIRECT_EN
            ind_q   <= 1'b0;
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            // Every busy cycle with mem_resp changes state, so "no state change"
            // while busy means a wait cycle.
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q != S_IDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == S_IDLE && bus.req_valid) begin
                op_q    <= bus.req_op;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
`ifdef MEM_STAGE_INDIRECT_EN
                ind_q   <= bus.req_indirect;
`endif
            end
`ifdef MEM_STAGE_INDIRECT_EN
            if (state_q == S_PTR && bus.mem_resp) begin
                ptr_q <= bus.mem_rdata[ADDR_WIDTH-1:0];
            end
`endif
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl

module tb_mem_stage_ctrl;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int WL = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_stage_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .WAIT_LIMIT(WL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access: accept cycle, nwait strobe cycles without response,
    // then the response cycle and one idle cycle after it.
    task automatic access(input string tag, input logic [1:0] op, input logic [15:0] addr,
                          input logic [15:0] wdata, input int nwait, input logic [15:0] rdata,
                          input logic [15:0] exp_rd, input logic [1:0] exp_mask,
                          input logic [15:0] exp_wd);
        logic [1:0] exp_strb;
        exp_strb = op[1] ? 2'b01 : 2'b10;
        step();
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.req_indirect = 1'b0;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.mem_resp     = 1'b0;
        @(negedge clk);
        chk({tag, ".acc_stall"}, 32'(bus.stall), 1);
        chk({tag, ".acc_strobe"}, 32'({bus.mem_read, bus.mem_write}), 0);
        step();
        bus.req_valid = 1'b0;
        bus.req_addr  = ~addr;
        bus.req_op    = ~op;
        bus.req_wdata = ~wdata;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            chk({tag, ".wait_strobe"}, 32'({bus.mem_read, bus.mem_write}), 32'(exp_strb));
            chk({tag, ".wait_stall"}, 32'({bus.stall, bus.rsp_valid}), 'h2);
            step();
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rdata;
        @(negedge clk);
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 1);
        chk({tag, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        chk({tag, ".stall_err"}, 32'({bus.stall, bus.err}), 0);
        chk({tag, ".strobe"}, 32'({bus.mem_read, bus.mem_write}), 32'(exp_strb));
        chk({tag, ".address"}, 32'(bus.mem_address), 32'(addr));
        chk({tag, ".wmask"}, 32'(bus.mem_wmask), 32'(exp_mask));
        if (op[1]) chk({tag, ".wdata"}, 32'(bus.mem_wdata), 32'(exp_wd));
        step();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        chk({tag, ".idle"}, 32'({bus.mem_read, bus.mem_write, bus.rsp_valid, bus.stall}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        bus.req_valid    = 1'b1;
        bus.req_op       = 2'b10;
        bus.req_indirect = 1'b0;
        bus.req_addr     = 16'h1234;
        bus.req_wdata    = 16'h5678;
        bus.mem_resp     = 1'b1;
        bus.mem_rdata    = 16'hFFFF;
        @(negedge clk);
        chk("rst.strobes", 32'({bus.mem_read, bus.mem_write}), 0);
        chk("rst.wmask", 32'(bus.mem_wmask), 0);
        chk("rst.address", 32'(bus.mem_address), 0);
        chk("rst.wdata", 32'(bus.mem_wdata), 0);
        chk("rst.rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 0);
        chk("rst.err", 32'(bus.err), 0);
        chk("rst.stall", 32'(bus.stall), 0);
        bus.req_valid = 1'b0;
        bus.mem_resp  = 1'b0;
        step();
        rst = 1'b0;

        // mem_resp while idle is ignored
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("idle_resp.rsp", 32'({bus.rsp_valid, bus.stall}), 0);
        step();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        chk("idle_resp.strobe", 32'({bus.mem_read, bus.mem_write}), 0);

        // load word, 3 wait cycles -> 4 read cycles
        access("lw", 2'b00, 16'h3000, 16'h0000, 3, 16'hBEEF, 16'hBEEF, 2'b00, 16'h0000);
        // byte stores on both lanes, word store
        access("sb1", 2'b11, 16'h1001, 16'h00A5, 1, 16'h0000, 16'h0000, 2'b10, 16'hA500);
        access("sb0", 2'b11, 16'h1000, 16'h00A5, 0, 16'h0000, 16'h0000, 2'b01, 16'h00A5);
        access("sw", 2'b10, 16'h2003, 16'h1234, 2, 16'hFFFF, 16'h0000, 2'b11, 16'h1234);
        // byte loads on both lanes
        access("lb0", 2'b01, 16'h1000, 16'h0000, 0, 16'h12F0, 16'h00F0, 2'b00, 16'h0000);
        access("lb1", 2'b01, 16'h1001, 16'h0000, 2, 16'h12F0, 16'h0012, 2'b00, 16'h0000);
        // response on the limit cycle wins over the timeout
        access("lim", 2'b00, 16'h0600, 16'h0000, WL, 16'h5555, 16'h5555, 2'b00, 16'h0000);

        // timeout: no response, err on 5th strobe cycle, then back-to-back accept
        step();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_addr  = 16'h0500;
        @(negedge clk);
        chk("to.acc", 32'(bus.stall), 1);
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < WL; i++) begin
            @(negedge clk);
            chk("to.wait", 32'({bus.mem_read, bus.err, bus.rsp_valid}), 'h4);
            step();
        end
        @(negedge clk);
        chk("to.err", 32'({bus.err, bus.rsp_valid, bus.stall, bus.mem_read}), 'hD);
        chk("to.rdata", 32'(bus.rsp_rdata), 0);
        step();
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        bus.req_addr  = 16'h0042;
        bus.req_wdata = 16'h9ABC;
        @(negedge clk);
        chk("b2b.after_to", 32'({bus.mem_read, bus.mem_write, bus.err, bus.stall}), 'h1);
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b.write", 32'({bus.mem_write, bus.mem_wmask}), 'h7);
        chk("b2b.addr", 32'(bus.mem_address), 'h0042);
        chk("b2b.wdata", 32'(bus.mem_wdata), 'h9ABC);
        step();
        bus.mem_resp = 1'b1;
        @(negedge clk);
        chk("b2b.rsp", 32'({bus.rsp_valid, bus.err}), 'h2);
        step();
        bus.mem_resp = 1'b0;

        // reset in the middle of an access
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_addr  = 16'h0700;
        step();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rmid.read", 32'(bus.mem_read), 1);
        bus.mem_resp = 1'b1;
        bus.mem_rdata = 16'h1111;
        rst = 1'b1;
        #1;
        chk("rmid.drop", 32'({bus.mem_read, bus.rsp_valid, bus.stall, bus.err}), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rmid.after", 32'({bus.mem_read, bus.rsp_valid, bus.stall}), 0);
        bus.mem_resp = 1'b0;
        access("rmid.next", 2'b00, 16'h0800, 16'h0000, 1, 16'h2222, 16'h2222, 2'b00, 16'h0000);

`ifdef MEM_STAGE_INDIRECT_EN
        // indirect load: pointer read at 0x2000, data read at 0x4000
        step();
        bus.req_valid    = 1'b1;
        bus.req_op       = 2'b00;
        bus.req_indirect = 1'b1;
        bus.req_addr     = 16'h2000;
        @(negedge clk);
        chk("ind.acc", 32'(bus.stall), 1);
        step();
        bus.req_valid    = 1'b0;
        bus.req_indirect = 1'b0;
        @(negedge clk);
        chk("ind.ptr_read", 32'({bus.mem_read, bus.mem_wmask}), 'h4);
        chk("ind.ptr_addr", 32'(bus.mem_address), 'h2000);
        step();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'h4000;
        @(negedge clk);
        chk("ind.ptr_rsp", 32'({bus.rsp_valid, bus.stall}), 'h1);
        step();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        chk("ind.data_addr", 32'(bus.mem_address), 'h4000);
        chk("ind.data_read", 32'({bus.mem_read, bus.rsp_valid}), 'h2);
        step();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 16'h7777;
        @(negedge clk);
        chk("ind.rsp", 32'({bus.rsp_valid, bus.rsp_rdata}), 'h17777);
        step();
        bus.mem_resp = 1'b0;

        // reset while in PTR
        bus.req_valid    = 1'b1;
        bus.req_indirect = 1'b1;
        bus.req_addr     = 16'h2100;
        step();
        bus.req_valid    = 1'b0;
        bus.req_indirect = 1'b0;
        @(negedge clk);
        chk("rptr.read", 32'(bus.mem_read), 1);
        bus.mem_resp = 1'b1;
        rst = 1'b1;
        #1;
        chk("rptr.drop", 32'({bus.mem_read, bus.rsp_valid, bus.stall}), 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rptr.after", 32'(bus.rsp_valid), 0);
        bus.mem_resp = 1'b0;
        access("rptr.next", 2'b01, 16'h3001, 16'h0000, 0, 16'hAB00, 16'h00AB, 2'b00, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
